uart_ram_dump: RTL and testbench
================================

UART_RAM_DUMP -- requirements
Module: uart_ram_dump

Interface
REQ-001 SHALL have parameter XLEN, 32, data RAM word width (only 32 supported).
REQ-002 SHALL have parameter ADDR_LEN, 14, RAM word-address width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  dump request pulse; sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  ADDR_LEN  first RAM word address.
REQ-007 SHALL have port word_cnt  input  ADDR_LEN+1  number of words to dump (0..2^ADDR_LEN).
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port done  output  1  one-cycle pulse after the checksum byte is issued.
REQ-010 SHALL have port ram_rd_en  output  1  RAM read strobe.
REQ-011 SHALL have port ram_addr  output  ADDR_LEN  RAM word address.
REQ-012 SHALL have port ram_rd_data  input  XLEN  RAM read data, valid exactly 1 cycle after ram_rd_en.
REQ-013 SHALL have port uart_tx_valid  output  1  one-cycle byte-issue pulse to the UART transmitter.
REQ-014 SHALL have port uart_tx_data  output  8  byte to send, valid with uart_tx_valid.
REQ-015 SHALL have port uart_tx_busy  input  1  UART transmitter busy.

Function
REQ-016 Frame SHALL be: header 0xA5, then word_cnt words, each sent LSB byte first, then one checksum byte.
REQ-017 Checksum SHALL be the mod-256 sum of all data bytes, excluding the header.
REQ-018 start_addr and word_cnt SHALL be latched on the accepted start; later input changes have no effect on the running frame.
REQ-019 FSM states SHALL be IDLE, HDR, RD, RDW, SEND, CSUM, FIN.
REQ-020 IDLE->HDR on start; HDR->RD after issue (or ->CSUM if word_cnt==0); RD->RDW after one cycle; RDW->SEND.
REQ-021 SEND->RD after byte 3 if words remain, otherwise SEND->CSUM.
REQ-022 CSUM->FIN after issue; FIN->IDLE in 1 cycle with done=1.
REQ-023 In RD, ram_rd_en SHALL be 1 for exactly one cycle; the word SHALL be captured in RDW into a 32-bit shift register.
REQ-024 A byte SHALL be issued (uart_tx_valid=1 for one cycle) only when uart_tx_busy==0 and the guard flag is clear.
REQ-025 The guard flag SHALL set on issue and clear after one cycle, so busy is never sampled in the cycle right after valid.
REQ-026 Issue states HDR, SEND and CSUM SHALL hold while uart_tx_busy==1, with no timeout.
REQ-027 ram_addr SHALL increment by 1 per word and wrap modulo 2^ADDR_LEN.
REQ-028 The remaining-word counter SHALL be ADDR_LEN+1 bits, so word_cnt=2^ADDR_LEN dumps the whole RAM.
REQ-029 start while busy==1 SHALL be ignored; start in the FIN cycle SHALL be ignored.
REQ-030 Maximum throughput SHALL be limited only by uart_tx_busy; no added idle cycles beyond RD/RDW per word.

Reset
REQ-031 rst SHALL force at the next edge: state=IDLE, busy=0, done=0, ram_rd_en=0, ram_addr=0, uart_tx_valid=0, uart_tx_data=0, checksum=0, guard=0.
REQ-032 rst mid-frame SHALL abort the frame with no further byte issued; rst has priority over start in the same cycle.

Structure
REQ-033 Package uart_dump_pkg SHALL hold the state enum typedef and the constant DUMP_HDR=8'hA5.
REQ-034 The module SHALL be a single module with no sub-modules; it is instantiated beside uart_mgr, sharing the tx path through a mux in soc.

Verification
REQ-035 RAM[0x10]=0x12345678, start_addr=0x10, word_cnt=1, tx_busy=0 -> bytes A5,78,56,34,12,14; done pulses once.
REQ-036 word_cnt=0 -> bytes A5,00; ram_rd_en never asserted.
REQ-037 start_addr=0x3FFF, word_cnt=2 -> ram_addr 0x3FFF then 0x0000; 10 bytes total.
REQ-038 tx_busy held 1 for 100 cycles after header -> no uart_tx_valid during hold; frame completes intact after release; second start during busy ignored.
REQ-039 rst asserted while sending byte 2 of a word -> all outputs 0 next cycle; a new start yields a complete, correct frame.
REQ-040 Model tx_busy rising 1 cycle after valid and staying high 10 cycles -> exactly one valid per byte, none dropped or duplicated.

Source files
------------

// File: rtl/uart_dump_pkg.sv
// Shared types and constants for the UART RAM dump engine.
package uart_dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        RD,
        RDW,
        SEND,
        CSUM,
        FIN
    } dump_state_e;

    localparam logic [7:0] DUMP_HDR = 8'hA5;

endpackage

// File: rtl/uart_ram_dump.sv
// Streams a block of RAM words out of a byte-wide UART transmitter as a
// framed dump: header byte, data bytes (LSB first), mod-256 checksum.
module uart_ram_dump
    import uart_dump_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_LEN = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_LEN-1:0] start_addr,
    input  logic [ADDR_LEN:0]   word_cnt,
    output logic                busy,
    output logic                done,
    output logic                ram_rd_en,
    output logic [ADDR_LEN-1:0] ram_addr,
    input  logic [XLEN-1:0]     ram_rd_data,
    output logic                uart_tx_valid,
    output logic [7:0]          uart_tx_data,
    input  logic                uart_tx_busy
);

    dump_state_e         state, state_d;
    logic [ADDR_LEN-1:0] addr_q;
    logic [ADDR_LEN:0]   remain_q;
    logic [XLEN-1:0]     shreg_q;
    logic [1:0]          byte_idx_q;
    logic [7:0]          csum_q;
    logic                guard_q;
    logic                can_issue;
    logic                issue;
    logic [7:0]          tx_byte;

    // The guard masks the cycle after an issue, before the transmitter
    // has had a chance to raise its busy flag.
    assign can_issue = !uart_tx_busy && !guard_q;

    always_comb begin
        state_d = state;
        issue   = 1'b0;
        tx_byte = 8'h00;
        case (state)
            IDLE: if (start) state_d = HDR;
            HDR: begin
                tx_byte = DUMP_HDR;
                if (can_issue) begin
                    issue   = 1'b1;
                    state_d = (remain_q == '0) ? CSUM : RD;
                end
            end
            RD:  state_d = RDW;
            RDW: state_d = SEND;
            SEND: begin
                tx_byte = shreg_q[7:0];
                if (can_issue) begin
                    issue = 1'b1;
                    if (byte_idx_q == 2'd3)
                        state_d = (remain_q == '0) ? CSUM : RD;
                end
            end
            CSUM: begin
                tx_byte = csum_q;
                if (can_issue) begin
                    issue   = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            guard_q    <= 1'b0;
        end else begin
            state   <= state_d;
            guard_q <= issue;
            case (state)
                IDLE: if (start) begin
                    addr_q     <= start_addr;
                    remain_q   <= word_cnt;
                    csum_q     <= '0;
                    byte_idx_q <= '0;
                end
                // Counter and address advance as the read is launched, so
                // the last-byte decision in SEND only needs remain_q.
                RD: begin
                    addr_q   <= addr_q + 1'b1;
                    remain_q <= remain_q - 1'b1;
                end
                RDW: begin
                    shreg_q    <= ram_rd_data;
                    byte_idx_q <= '0;
                end
                SEND: if (issue) begin
                    shreg_q    <= {8'h00, shreg_q[XLEN-1:8]};
                    csum_q     <= csum_q + shreg_q[7:0];
                    byte_idx_q <= byte_idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy          = (state != IDLE);
    assign done          = (state == FIN);
    assign ram_rd_en     = (state == RD);
    assign ram_addr      = addr_q;
    assign uart_tx_valid = issue;
    assign uart_tx_data  = tx_byte;

endmodule

// File: tb/tb_uart_ram_dump.sv
// Scoreboard bench for uart_ram_dump: RAM and UART models, vector table
// plus hand-written hold, abort and start-filtering sequences.
module tb_uart_ram_dump;

    logic        clk;
    logic        rst;
    logic        start;
    logic [13:0] start_addr;
    logic [14:0] word_cnt;
    logic        busy;
    logic        done;
    logic        ram_rd_en;
    logic [13:0] ram_addr;
    logic [31:0] ram_rd_data;
    logic        uart_tx_valid;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_busy;

    uart_ram_dump #(.XLEN(32), .ADDR_LEN(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .word_cnt     (word_cnt),
        .busy         (busy),
        .done         (done),
        .ram_rd_en    (ram_rd_en),
        .ram_addr     (ram_addr),
        .ram_rd_data  (ram_rd_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [31:0] mem [0:16383];
    logic [7:0]  exp_q [$];
    logic [13:0] exp_a [$];
    logic [7:0]  frame_bytes [$];
    int nbytes, rd_cnt, done_cnt;

    bit       busy_mode;
    bit       hold;
    bit       v_neg;
    logic [4:0] ctr;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // RAM: registered read, data one cycle after the strobe
    always @(posedge clk)
        if (ram_rd_en) ram_rd_data <= mem[ram_addr];

    // UART: busy rises the cycle after a valid and lasts 10 cycles in mode 1
    always @(posedge clk) begin
        if (busy_mode && v_neg) ctr <= 5'd10;
        else if (ctr != 0)      ctr <= ctr - 5'd1;
    end
    assign uart_tx_busy = hold || (ctr != 5'd0);

    always @(negedge clk) begin
        v_neg = uart_tx_valid && !rst;
        if (!rst) begin
            if (uart_tx_valid) begin
                nbytes++;
                frame_bytes.push_back(uart_tx_data);
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", uart_tx_data);
                end else begin
                    check("tx_byte", {24'h0, uart_tx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (ram_rd_en) begin
                rd_cnt++;
                if (exp_a.size() == 0) begin
                    total++;
                    $display("FAIL rd_unexpected: got addr %0h expected none", ram_addr);
                end else begin
                    check("ram_addr", {18'h0, ram_addr}, {18'h0, exp_a.pop_front()});
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic push_frame(input logic [13:0] a, input logic [14:0] c);
        logic [13:0] ad;
        logic [7:0]  sum;
        logic [31:0] w;
        ad  = a;
        sum = 8'h00;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < int'(c); i++) begin
            exp_a.push_back(ad);
            w = mem[ad];
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(w[8*b +: 8]);
                sum = sum + w[8*b +: 8];
            end
            ad = ad + 14'd1;
        end
        exp_q.push_back(sum);
    endtask

    task automatic clear_counts();
        nbytes = 0;
        rd_cnt = 0;
        done_cnt = 0;
        frame_bytes.delete();
    endtask

    task automatic wait_bytes(input int n, input int limit);
        int k;
        k = 0;
        while (nbytes < n && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        check("byte_wait_in_time", {31'h0, k < limit}, 32'd1);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (done_cnt == 0 && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        check("done_in_time", {31'h0, done_cnt != 0}, 32'd1);
    endtask

    task automatic pulse_start(input logic [13:0] a, input logic [14:0] c);
        @(negedge clk);
        start_addr = a;
        word_cnt   = c;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [13:0] a, input logic [14:0] c, input bit m, input int tot);
        busy_mode = m;
        clear_counts();
        push_frame(a, c);
        pulse_start(a, c);
        #1 check("busy_after_start", {31'h0, busy}, 32'd1);
        wait_done(5000);
        repeat (4) @(negedge clk);
        #1;
        check("done_once", done_cnt, 32'd1);
        check("byte_count", nbytes, tot);
        check("rd_count", rd_cnt, {17'h0, c});
        check("exp_bytes_left", exp_q.size(), 32'd0);
        check("exp_addr_left", exp_a.size(), 32'd0);
        check("busy_after_done", {31'h0, busy}, 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_done"}, {31'h0, done}, 32'd0);
        check({tag, "_rd_en"}, {31'h0, ram_rd_en}, 32'd0);
        check({tag, "_addr"}, {18'h0, ram_addr}, 32'd0);
        check({tag, "_valid"}, {31'h0, uart_tx_valid}, 32'd0);
        check({tag, "_data"}, {24'h0, uart_tx_data}, 32'd0);
    endtask

    typedef struct {
        logic [13:0] addr;
        logic [14:0] cnt;
        bit          mode;
        int          tot;
    } vec_t;

    vec_t        tbl [5];
    logic [7:0]  ref35 [6];
    int          n0;

    initial begin
        tbl[0] = '{14'h0010, 15'd1, 1'b0, 6};
        tbl[1] = '{14'h0020, 15'd0, 1'b0, 2};
        tbl[2] = '{14'h3FFF, 15'd2, 1'b0, 10};
        tbl[3] = '{14'h0100, 15'd3, 1'b1, 14};
        tbl[4] = '{14'h0200, 15'd5, 1'b1, 22};
        ref35  = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12, 8'h14};

        for (int i = 0; i < 16384; i++)
            mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'hC3A50F1E;
        mem[14'h0010] = 32'h12345678;

        rst = 1'b1; start = 1'b0; start_addr = '0; word_cnt = '0;
        hold = 1'b0; busy_mode = 1'b0; ctr = '0; v_neg = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].addr, tbl[i].cnt, tbl[i].mode, tbl[i].tot);
            if (i == 0) begin
                check("frame0_len", frame_bytes.size(), 32'd6);
                for (int j = 0; j < 6 && j < frame_bytes.size(); j++)
                    check("frame0_byte", {24'h0, frame_bytes[j]}, {24'h0, ref35[j]});
            end
        end

        // UART held busy after the header; stray starts during the frame
        // and in the FIN cycle must be ignored.
        busy_mode = 1'b0;
        clear_counts();
        push_frame(14'h0080, 15'd2);
        pulse_start(14'h0080, 15'd2);
        wait_bytes(1, 200);
        hold = 1'b1;
        n0 = nbytes;
        pulse_start(14'h0000, 15'd5);
        repeat (100) @(negedge clk);
        #1 check("hold_no_valid", nbytes, n0);
        hold = 1'b0;
        wait_done(2000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("hold_byte_count", nbytes, 32'd10);
        check("hold_done_once", done_cnt, 32'd1);
        check("hold_exp_left", exp_q.size(), 32'd0);
        check("fin_start_ignored", {31'h0, busy}, 32'd0);

        // Abort mid-word after the second data byte of the first word
        clear_counts();
        push_frame(14'h0040, 15'd3);
        pulse_start(14'h0040, 15'd3);
        wait_bytes(3, 200);
        rst = 1'b1;
        @(negedge clk); #1;
        check_reset_outputs("abort");
        exp_q.delete();
        exp_a.delete();
        rst = 1'b0;
        n0 = nbytes;
        repeat (20) @(negedge clk);
        #1 check("abort_silent", nbytes, n0);
        run_frame(14'h0040, 15'd3, 1'b0, 14);

        // Reset wins over a simultaneous start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; start_addr = 14'h0010; word_cnt = 15'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        #1 check("rst_over_start", {31'h0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        #1 check("rst_over_start_idle", {31'h0, busy}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
